regfile_master: RTL

REGFILE_MASTER -- requirements
Module: regfile_master

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_master.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file master: command opcodes and FSM state encoding.
package regfile_pkg;

    // Command opcodes carried on CmdOp
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    // Master FSM states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RSP     = 3'd4,
        S_FILL    = 3'd5
    } state_t;

endpackage

// File: rtl/regfile_master.sv
// Command-driven master for a synchronous register-file peer.
// Accepts one READ / WRITE / FILL command at a time in IDLE, drives the peer
// through registered strobes, and returns read data on a valid/ready response.
module regfile_master
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int ADDR  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [ADDR-1:0]  CmdAddr,
    input  logic [WIDTH-1:0] CmdData,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic [ADDR-1:0]  RF_Address,
    output logic             RF_WrEn,
    output logic             RF_RdEn,
    output logic [WIDTH-1:0] RF_WrData,
    input  logic [WIDTH-1:0] RF_RdData,
    output logic             Busy
);

    // Final address of a FILL sweep; the sweep stops here instead of wrapping.
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    state_t           r_state;
    op_t              r_cmd_op;
    logic [ADDR-1:0]  r_cmd_addr;
    logic [WIDTH-1:0] r_cmd_data;
    logic [ADDR-1:0]  r_fill_cnt;
    logic [ADDR-1:0]  r_address;
    logic             r_wr_en;
    logic             r_rd_en;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_accept;
    logic             w_fill_last;

    assign w_accept    = (r_state == S_IDLE) && CmdValid;
    // A FILL sweep ends on its final address; the opcode qualifier keeps a
    // corrupted state from ever looping the sweep.
    assign w_fill_last = (r_fill_cnt == LAST_ADDR) || (r_cmd_op != OP_FILL);

    // FSM, fill counter and all registered outputs in one place
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cmd_op    <= OP_READ;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_fill_cnt  <= '0;
            r_address   <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_op   <= op_t'(CmdOp);
                        r_cmd_addr <= CmdAddr;
                        r_cmd_data <= CmdData;
                        case (op_t'(CmdOp))
                            OP_WRITE: begin
                                r_state   <= S_WR;
                                r_wr_en   <= 1'b1;
                                r_address <= CmdAddr;
                                r_wr_data <= CmdData;
                            end
                            OP_READ: begin
                                r_state   <= S_RD;
                                r_rd_en   <= 1'b1;
                                r_address <= CmdAddr;
                            end
                            OP_FILL: begin
                                r_state    <= S_FILL;
                                r_wr_en    <= 1'b1;
                                r_address  <= '0;
                                r_wr_data  <= CmdData;
                                r_fill_cnt <= '0;
                            end
                            default: begin
                                // Reserved opcode: consumed, no peer activity.
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_RD: begin
                    r_rd_en   <= 1'b0;
                    r_address <= r_cmd_addr;
                    r_state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Peer data is valid now, one cycle after the read strobe.
                    r_rsp_data  <= RF_RdData;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (RspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (w_fill_last) begin
                        r_wr_en <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        r_address  <= r_fill_cnt + 1'b1;
                        r_wr_data  <= r_cmd_data;
                    end
                end
                default: begin
                    r_wr_en     <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign CmdReady   = (r_state == S_IDLE);
    assign Busy       = (r_state != S_IDLE);
    assign RspValid   = r_rsp_valid;
    assign RspData    = r_rsp_data;
    assign RF_Address = r_address;
    assign RF_WrEn    = r_wr_en;
    assign RF_RdEn    = r_rd_en;
    assign RF_WrData  = r_wr_data;

endmodule
